// File: rtl/seg7_scan_ctrl.sv
// Eight-digit common-anode 7-segment scan controller with a pending/shown word buffer.
// New words are swapped in only at frame boundaries so a frame never mixes two words.
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [7:0]  in_dp_mask,
  input  logic        in_blank_lz,
  output logic [6:0]  SEG,
  output logic [7:0]  AN,
  output logic        DP,
  output logic        frame_tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp_mask;
    logic        blank_lz;
  } word_t;

  word_t            shown;
  word_t            pending;
  logic             pending_full;
  logic [CNT_W-1:0] div_cnt;
  logic [2:0]       digit_idx;

  logic       slot_end;
  logic       boundary;
  logic       accept;
  logic [3:0] nibble;
  logic [2:0] hi_idx;
  logic       blanked;

  function automatic logic [6:0] seg7_decode(input logic [3:0] n);
    case (n)
      4'h0:    seg7_decode = 7'b1000000;
      4'h1:    seg7_decode = 7'b1111001;
      4'h2:    seg7_decode = 7'b0100100;
      4'h3:    seg7_decode = 7'b0110000;
      4'h4:    seg7_decode = 7'b0011001;
      4'h5:    seg7_decode = 7'b0010010;
      4'h6:    seg7_decode = 7'b0000010;
      4'h7:    seg7_decode = 7'b1111000;
      4'h8:    seg7_decode = 7'b0000000;
      4'h9:    seg7_decode = 7'b0010000;
      4'hA:    seg7_decode = 7'b0001000;
      4'hB:    seg7_decode = 7'b0000011;
      4'hC:    seg7_decode = 7'b1000110;
      4'hD:    seg7_decode = 7'b0100001;
      4'hE:    seg7_decode = 7'b0000110;
      default: seg7_decode = 7'b0001110;
    endcase
  endfunction

  assign slot_end = (div_cnt == DIV_LAST);
  assign boundary = slot_end && (digit_idx == 3'd7);
  assign in_ready = ~pending_full;
  assign accept   = in_valid && ~pending_full;

  // Highest nonzero nibble of the shown word; digits above it are leading zeros.
  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    hi_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (shown.data[4*k +: 4] != 4'h0) hi_idx = 3'(k);
    end
    nibble  = shown.data[{digit_idx, 2'b00} +: 4];
    blanked = shown.blank_lz && (digit_idx > hi_idx);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shown        <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      div_cnt      <= '0;
      digit_idx    <= 3'd0;
      frame_tick   <= 1'b0;
      AN           <= 8'hFF;
      SEG          <= 7'h7F;
      DP           <= 1'b1;
    end else begin
      div_cnt    <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) digit_idx <= digit_idx + 3'd1;
      frame_tick <= boundary;

      // A full pending buffer blocks accepts, so the swap and the capture never collide.
      if (boundary && pending_full) begin
        shown        <= pending;
        pending_full <= 1'b0;
      end else if (accept) begin
        pending      <= '{data: in_data, dp_mask: in_dp_mask, blank_lz: in_blank_lz};
        pending_full <= 1'b1;
      end

      if (blanked) begin
        AN  <= 8'hFF;
        SEG <= 7'h7F;
        DP  <= 1'b1;
      end else begin
        AN  <= ~(8'b1 << digit_idx);
        SEG <= seg7_decode(nibble);
        DP  <= ~shown.dp_mask[digit_idx];
      end
    end
  end

endmodule
